// File: rtl/ext_llr_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ext_llr_pipe
//  Purpose  : Multi-lane two-stage extrinsic-LLR unit (max-log / max*, 0.75 scaling)
//  Revision : 1.0
// ============================================================================
module ext_llr_pipe #(
    parameter int N      = 5,
    parameter int M      = 6,
    parameter int LANES  = 4,
    parameter int CORR_T = 2,
    parameter int SATW   = 8
) (
    input  logic                        Clock,
    input  logic                        nReset,
    input  logic                        en,
    input  logic                        clear,
    input  logic                        in_valid,
    input  logic                        mode_maxstar,
    input  logic                        scale_en,
    input  logic [LANES-1:0][N-1:0]     ba2,
    input  logic [LANES-1:0][3:0][M:0]  epsilon,
    output logic                        out_valid,
    output logic [LANES-1:0][M-1:0]     be1,
    output logic [LANES-1:0][SATW-1:0]  sat_count
);

    localparam logic        [M+2:0]  c_CORR    = (M+3)'(CORR_T);
    localparam logic signed [M+2:0]  c_BE_MAX  = (M+3)'((1 << (M-1)) - 1);
    localparam logic signed [M+2:0]  c_BE_MIN  = -c_BE_MAX;
    localparam logic        [SATW-1:0] c_SAT_MAX = '1;

    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic scale1_q;

    always_comb begin
        v1_d = in_valid & ~clear;
        v2_d = v1_q & ~clear;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            scale1_q <= 1'b0;
        end else if (en) begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            scale1_q <= scale_en;
        end
    end

    assign out_valid = v2_q;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [M:0]    w_e1, w_e2, w_e3, w_e4;
        logic signed [N-1:0]  w_ba;
        logic signed [M+1:0]  w_ba_x, w_e1_x, w_e3_x, w_s2, w_s4;
        logic signed [M+1:0]  w_a_max, w_b_max;
        logic signed [M+2:0]  w_dif_a, w_dif_b;
        logic        [M+2:0]  w_abs_a, w_abs_b;
        logic                 w_corr_a, w_corr_b;
        logic signed [M+1:0]  a_d, a_q, b_d, b_q;
        logic signed [M+2:0]  w_d, w_ds;
        logic                 w_hi, w_lo;
        logic        [M-1:0]  be1_d, be1_q;
        logic        [SATW-1:0] sat_d, sat_q;

        assign w_e1 = epsilon[gi][0];
        assign w_e2 = epsilon[gi][1];
        assign w_e3 = epsilon[gi][2];
        assign w_e4 = epsilon[gi][3];
        assign w_ba = ba2[gi];

        // Stage 1: everything widened to M+2 so the sums and +1 never wrap
        assign w_ba_x = {{(M+2-N){w_ba[N-1]}}, w_ba};
        assign w_e1_x = {w_e1[M], w_e1};
        assign w_e3_x = {w_e3[M], w_e3};
        assign w_s2   = {w_e2[M], w_e2} + w_ba_x;
        assign w_s4   = {w_e4[M], w_e4} + w_ba_x;

        assign w_dif_a  = {w_e1_x[M+1], w_e1_x} - {w_s2[M+1], w_s2};
        assign w_dif_b  = {w_e3_x[M+1], w_e3_x} - {w_s4[M+1], w_s4};
        assign w_abs_a  = w_dif_a[M+2] ? -w_dif_a : w_dif_a;
        assign w_abs_b  = w_dif_b[M+2] ? -w_dif_b : w_dif_b;
        assign w_corr_a = mode_maxstar && (w_abs_a < c_CORR);
        assign w_corr_b = mode_maxstar && (w_abs_b < c_CORR);

        assign w_a_max = (w_e1_x > w_s2) ? w_e1_x : w_s2;
        assign w_b_max = (w_e3_x > w_s4) ? w_e3_x : w_s4;
        assign a_d     = w_a_max + {{(M+1){1'b0}}, w_corr_a};
        assign b_d     = w_b_max + {{(M+1){1'b0}}, w_corr_b};

        // Stage 2: D - floor(D/4) gives the 0.75 scale without a multiplier
        assign w_d  = {b_q[M+1], b_q} - {a_q[M+1], a_q};
        assign w_ds = scale1_q ? (w_d - (w_d >>> 2)) : w_d;
        assign w_hi = (w_ds > c_BE_MAX);
        assign w_lo = (w_ds < c_BE_MIN);

        always_comb begin
            if (w_hi) begin
                be1_d = c_BE_MAX[M-1:0];
            end else if (w_lo) begin
                be1_d = c_BE_MIN[M-1:0];
            end else begin
                be1_d = w_ds[M-1:0];
            end
        end

        always_comb begin
            sat_d = sat_q;
            if (clear) begin
                sat_d = '0;
            end else if (v1_q && (w_hi || w_lo) && (sat_q != c_SAT_MAX)) begin
                sat_d = sat_q + 1'b1;
            end
        end

        always_ff @(posedge Clock or negedge nReset) begin
            if (!nReset) begin
                a_q   <= '0;
                b_q   <= '0;
                be1_q <= '0;
                sat_q <= '0;
            end else if (en) begin
                a_q   <= a_d;
                b_q   <= b_d;
                be1_q <= be1_d;
                sat_q <= sat_d;
            end
        end

        assign be1[gi]       = be1_q;
        assign sat_count[gi] = sat_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_ext_llr_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ext_llr_pipe
//  Purpose  : Directed scoreboard bench for ext_llr_pipe
//  Revision : 1.0
// ============================================================================
module tb_ext_llr_pipe;

    localparam int N      = 5;
    localparam int M      = 6;
    localparam int LANES  = 4;
    localparam int CORR_T = 2;
    localparam int SATW   = 8;
    localparam int LIM    = (1 << (M-1)) - 1;
    localparam int SMAX   = (1 << SATW) - 1;

    logic Clock = 1'b0;
    logic nReset = 1'b0;
    logic en = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic mode_maxstar = 1'b0;
    logic scale_en = 1'b0;
    logic [LANES-1:0][N-1:0]    ba2 = '0;
    logic [LANES-1:0][3:0][M:0] epsilon = '0;
    logic                       out_valid;
    logic [LANES-1:0][M-1:0]    be1;
    logic [LANES-1:0][SATW-1:0] sat_count;

    always #5 Clock = ~Clock;

    ext_llr_pipe #(.N(N), .M(M), .LANES(LANES), .CORR_T(CORR_T), .SATW(SATW)) u_dut (
        .Clock(Clock), .nReset(nReset), .en(en), .clear(clear), .in_valid(in_valid),
        .mode_maxstar(mode_maxstar), .scale_en(scale_en), .ba2(ba2), .epsilon(epsilon),
        .out_valid(out_valid), .be1(be1), .sat_count(sat_count)
    );

    typedef struct packed {
        logic [LANES-1:0][M-1:0] be;
        logic [LANES-1:0]        clip;
        logic [31:0]             due;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   en_cnt = 0;
    int   exp_sat[LANES];
    int   eps_v[LANES][4];
    int   ba_v[LANES];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Behavioural reference in plain integers
    function automatic void model(input int l, output logic [M-1:0] be, output logic clip);
        int s2, s4, a, b, d;
        s2 = eps_v[l][1] + ba_v[l];
        s4 = eps_v[l][3] + ba_v[l];
        a  = (eps_v[l][0] > s2) ? eps_v[l][0] : s2;
        b  = (eps_v[l][2] > s4) ? eps_v[l][2] : s4;
        if (mode_maxstar) begin
            if ((eps_v[l][0] - s2 < CORR_T) && (s2 - eps_v[l][0] < CORR_T)) a++;
            if ((eps_v[l][2] - s4 < CORR_T) && (s4 - eps_v[l][2] < CORR_T)) b++;
        end
        d = b - a;
        if (scale_en) d = d - (d >>> 2);
        clip = 1'b0;
        if (d > LIM) begin
            d = LIM; clip = 1'b1;
        end else if (d < -LIM) begin
            d = -LIM; clip = 1'b1;
        end
        be = d[M-1:0];
    endfunction

    task automatic apply();
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < 4; k++) epsilon[l][k] = (M+1)'(eps_v[l][k]);
            ba2[l] = N'(ba_v[l]);
        end
    endtask

    task automatic set_lane(input int l, input int e1, input int e2, input int e3, input int e4, input int b);
        eps_v[l][0] = e1; eps_v[l][1] = e2; eps_v[l][2] = e3; eps_v[l][3] = e4;
        ba_v[l] = b;
        apply();
    endtask

    task automatic rand_lanes(input int from);
        for (int l = from; l < LANES; l++) begin
            for (int k = 0; k < 4; k++) eps_v[l][k] = int'($urandom_range(127)) - 64;
            ba_v[l] = int'($urandom_range(31)) - 16;
        end
        apply();
    endtask

    // One clock: push expectation for the sample being loaded, then check outputs
    task automatic cycle();
        bit   was_en, do_push, do_clr;
        exp_t e, got;
        was_en  = en;
        do_clr  = en && clear && nReset;
        do_push = en && in_valid && !clear && nReset;
        e = '0;
        if (do_push) begin
            for (int l = 0; l < LANES; l++) model(l, e.be[l], e.clip[l]);
        end
        @(posedge Clock);
        #1;
        if (!nReset) begin
            chk("rst_valid", {31'b0, out_valid}, 0);
        end else if (was_en) begin
            en_cnt++;
            if (do_clr) begin
                sbq.delete();
                for (int l = 0; l < LANES; l++) exp_sat[l] = 0;
            end
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    chk("spurious_valid", {31'b0, out_valid}, 0);
                end else begin
                    got = sbq.pop_front();
                    chk("latency", en_cnt, got.due);
                    for (int l = 0; l < LANES; l++) begin
                        chk($sformatf("be1_l%0d", l), $signed(be1[l]), $signed(got.be[l]));
                        if (got.clip[l] && exp_sat[l] < SMAX) exp_sat[l]++;
                    end
                end
            end else if (sbq.size() > 0 && sbq[0].due <= en_cnt) begin
                chk("missing_valid", {31'b0, out_valid}, 1);
                void'(sbq.pop_front());
            end
            if (do_push) begin
                e.due = en_cnt + 1;
                sbq.push_back(e);
            end
        end
        if (nReset) begin
            for (int l = 0; l < LANES; l++)
                chk($sformatf("sat_l%0d", l), {24'b0, sat_count[l]}, exp_sat[l]);
        end
    endtask

    logic                       snap_v;
    logic [LANES-1:0][M-1:0]    snap_be;
    logic [LANES-1:0][SATW-1:0] snap_sat;

    initial begin
        for (int l = 0; l < LANES; l++) exp_sat[l] = 0;

        // Reset: outputs stay zero even with active inputs
        en = 1'b1; in_valid = 1'b1;
        rand_lanes(0);
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        for (int l = 0; l < LANES; l++) begin
            chk("rst_be1", $signed(be1[l]), 0);
            chk("rst_sat", {24'b0, sat_count[l]}, 0);
        end
        in_valid = 1'b0;
        nReset   = 1'b1;
        cycle();

        // Latency
        set_lane(0, 10, 5, 20, 4, 3); rand_lanes(1);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("lat_c1_valid", {31'b0, out_valid}, 0);
        cycle();
        chk("lat_c2_valid", {31'b0, out_valid}, 1);
        chk("lat_be1", $signed(be1[0]), 10);
        cycle();

        // max* vs max-log on the same input
        set_lane(0, 10, 8, 20, 4, 3);
        mode_maxstar = 1'b1; in_valid = 1'b1;
        cycle();
        mode_maxstar = 1'b0;
        cycle();
        in_valid = 1'b0;
        chk("maxstar_be1", $signed(be1[0]), 8);
        cycle();
        chk("maxlog_be1", $signed(be1[0]), 9);

        // Scaling, then per-sample toggling
        set_lane(0, 10, 5, 20, 4, 3);
        scale_en = 1'b1; in_valid = 1'b1;
        cycle();
        set_lane(0, 20, 4, 10, 5, 3);
        cycle();
        in_valid = 1'b0; scale_en = 1'b0;
        chk("scale_pos", $signed(be1[0]), 8);
        cycle();
        chk("scale_neg", $signed(be1[0]), -7);
        for (int i = 0; i < 8; i++) begin
            rand_lanes(0);
            scale_en = i[0]; mode_maxstar = i[1]; in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0; scale_en = 1'b0; mode_maxstar = 1'b0;
        repeat (2) cycle();

        // Flush with data in flight
        for (int i = 0; i < 3; i++) begin
            rand_lanes(0); in_valid = 1'b1;
            cycle();
        end
        clear = 1'b1;
        cycle();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_valid1", {31'b0, out_valid}, 0);
        chk("clr_sat", sat_count, 0);
        cycle();
        chk("clr_valid2", {31'b0, out_valid}, 0);

        // Saturation both ways, then counter ceiling
        rand_lanes(1);
        set_lane(0, -64, -64, 63, 0, -16); in_valid = 1'b1;
        cycle();
        set_lane(0, 63, 0, -64, -64, -16);
        cycle();
        in_valid = 1'b0;
        chk("sat_pos_be1", $signed(be1[0]), 31);
        chk("sat_pos_cnt", {24'b0, sat_count[0]}, 1);
        cycle();
        chk("sat_neg_be1", $signed(be1[0]), -31);
        chk("sat_neg_cnt", {24'b0, sat_count[0]}, 2);
        set_lane(0, -64, -64, 63, 0, -16); in_valid = 1'b1;
        repeat (300) cycle();
        in_valid = 1'b0;
        repeat (2) cycle();
        chk("sat_ceiling", {24'b0, sat_count[0]}, SMAX);

        // Stall mid-stream with changing inputs
        for (int i = 0; i < 10; i++) begin
            rand_lanes(0); in_valid = 1'b1;
            if (i == 4) begin
                en = 1'b0;
                snap_v = out_valid; snap_be = be1; snap_sat = sat_count;
                for (int s = 0; s < 3; s++) begin
                    rand_lanes(0);
                    cycle();
                    chk("stall_valid", {31'b0, out_valid}, {31'b0, snap_v});
                    chk("stall_be1", {8'b0, be1}, {8'b0, snap_be});
                    chk("stall_sat", sat_count, snap_sat);
                end
                en = 1'b1;
                rand_lanes(0);
            end
            cycle();
        end
        in_valid = 1'b0;
        repeat (2) cycle();

        // clear while stalled must do nothing
        for (int i = 0; i < 2; i++) begin
            rand_lanes(0); in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0; en = 1'b0; clear = 1'b1;
        snap_v = out_valid; snap_sat = sat_count;
        cycle();
        chk("clr_noen_valid", {31'b0, out_valid}, {31'b0, snap_v});
        chk("clr_noen_sat", sat_count, snap_sat);
        clear = 1'b0; en = 1'b1;
        repeat (3) cycle();

        // Asynchronous reset between edges with data in flight
        for (int i = 0; i < 3; i++) begin
            rand_lanes(0); in_valid = 1'b1;
            cycle();
        end
        #3 nReset = 1'b0;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 0);
        chk("arst_be1", {8'b0, be1}, 0);
        chk("arst_sat", sat_count, 0);
        sbq.delete();
        for (int l = 0; l < LANES; l++) exp_sat[l] = 0;
        in_valid = 1'b0;
        repeat (2) cycle();
        nReset = 1'b1;
        rand_lanes(0); in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("post_rst_c1", {31'b0, out_valid}, 0);
        cycle();
        chk("post_rst_c2", {31'b0, out_valid}, 1);

        repeat (3) cycle();
        chk("sb_empty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ext_llr_pipe.md
Name: ext_llr_pipe

Overview:
- Multi-lane, two-stage pipelined extrinsic-LLR unit for the fully parallel turbo decoder datapath.
- Each lane computes be1 = clip(max(eps3, eps4+ba2) - max(eps1, eps2+ba2)).
- Runtime options: max-log or max* (constant-correction) selection, and 0.75 extrinsic scaling.
- Adds valid tracking, global stall/flush, and per-lane saturation counters; sits between the alpha/beta recursion and the interleaver write port.

Parameters:
- N, 5: ba2 width, signed; N <= M+1 required.
- M, 6: be1 width, signed. Epsilon inputs are M+1 bits, signed.
- LANES, 4: number of independent parallel lanes.
- CORR_T, 2: max* threshold; add +1 when |x-y| < CORR_T.
- SATW, 8: width of each per-lane saturation counter.

Ports:
- Clock  in  1  rising-edge clock
- nReset  in  1  asynchronous active-low reset
- en  in  1  pipeline advance; 0 freezes every register
- clear  in  1  synchronous flush, effective only when en=1
- in_valid  in  1  input sample valid
- mode_maxstar  in  1  0 = max-log, 1 = max* with correction
- scale_en  in  1  1 = multiply difference by 0.75 before clipping
- ba2  in  LANES x N  per-lane a-priori term, signed
- epsilon  in  LANES x 4 x (M+1)  per-lane eps[4:1], signed
- out_valid  out  1  be1 valid
- be1  out  LANES x M  clipped extrinsic LLR, signed
- sat_count  out  LANES x SATW  per-lane saturation event counter, saturating

Behaviour:
- Reset (async, nReset=0): all pipeline registers, out_valid, be1 and sat_count are 0. Reset mid-operation drops in-flight data; there is no recovery of it.
- Stage 1, registered when en=1:
  - s2 = eps2 + ba2 and s4 = eps4 + ba2, both sign-extended to M+2 bits.
  - A = max(eps1, s2), B = max(eps3, s4); a tie selects either (equal values).
  - If mode_maxstar=1: add +1 to A when |eps1 - s2| < CORR_T, and to B when |eps3 - s4| < CORR_T.
  - A and B are M+2 bits; no overflow by construction.
  - Stage 1 also registers in_valid and scale_en. mode and scale are sampled with the data they apply to, so changing them mid-stream affects only subsequent samples.
- Stage 2, registered when en=1:
  - D = B - A, M+3 bits.
  - If scale_en: D' = D - (D >>> 2), arithmetic shift, floor. Otherwise D' = D.
  - be1 = D' saturated symmetrically to [-(2^(M-1)-1), +(2^(M-1)-1)], i.e. ±31 for M=6. -2^(M-1) is never produced.
  - out_valid <= stage-1 valid.
- Latency: exactly 2 en-high cycles from input to be1/out_valid. Throughput is 1 sample per en-high cycle.
- en=0: all registers, including sat_count, hold their values. Inputs are ignored. out_valid holds its value; consumers qualify it with en.
- clear=1 with en=1: both valid bits go to 0 next cycle and sat_count goes to 0. Data registers may load freely. clear with en=0 has no effect.
- sat_count[l]:
  - Increments when a stage-2 load with a valid sample clips lane l.
  - Stops at 2^SATW-1.
  - clear has priority over increment in the same cycle.
- be1 updates on every en-high cycle, even for invalid samples. Only out_valid qualifies it.
- Lanes are fully independent; the only shared controls are en, clear, mode_maxstar and scale_en.

Test Plan:
- Reset and latency:
  - nReset pulse, then en=1.
  - Lane0: eps1=10, eps2=5, eps3=20, eps4=4, ba2=3, max-log, no scaling, in_valid=1 at cycle 0.
  - Expect be1[0]=10 with out_valid=1 at cycle 2; all outputs 0 during reset.
- max* correction:
  - eps1=10, eps2=8, ba2=3 → A=11+1=12.
  - eps3=20, eps4=4 → B=20 (d=13, no correction).
  - Expect be1=8. The same input with mode_maxstar=0 gives 9.
- Scaling:
  - D=+10 with scale_en=1 → be1=8.
  - D=-10 → be1=-7.
  - Toggle scale_en on alternate samples; each output must follow its own sample's setting.
- Saturation:
  - eps3=63, eps4=0, ba2=-16, eps1=-64, eps2=-64 → D=127 → be1=+31, sat_count[0]=1.
  - Mirrored input → be1=-31, never -32.
  - Drive 300 saturating samples → sat_count holds at 255.
- Stall/flush:
  - Deassert en for 3 cycles mid-stream → be1, out_valid and sat_count are frozen, and no sample is lost or duplicated.
  - Assert clear with en=1 → out_valid=0 for the next two cycles (in_valid low), sat_count=0.
  - clear with en=0 → no change.
- Reset mid-operation:
  - Assert nReset low asynchronously between clock edges with valid data in flight → out_valid and be1 drop to 0 immediately.
  - After release, the first output appears 2 cycles after the first new valid input.
